// File: rtl/dot_product_engine_pkg.sv
// rtl/dot_product_engine_pkg.sv - shared states and width helpers for dot_product_engine
package dot_pkg;

  // Controller states; kept as plain constants so older tools and dumps read them as numbers.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACC  = 2'd1;
  localparam state_t ST_LAST = 2'd2;

  // A full product is this many operand widths wide.
  localparam int PROD_FACTOR = 2;

  function automatic int prod_width(input int data_w);
    return PROD_FACTOR * data_w;
  endfunction

  // Wide enough that LEN worst-case products never wrap in either mode.
  function automatic int acc_width(input int data_w, input int len);
    return prod_width(data_w) + $clog2(len);
  endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// rtl/dot_product_engine_if.sv - operand stream and result bus of dot_product_engine
interface dot_product_engine_if #(
  parameter int DATA_W = 8,
  parameter int LEN    = 2
);
  import dot_pkg::*;

  localparam int ACC_W = acc_width(DATA_W, LEN);

  logic              start;
  logic              signed_mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [ACC_W-1:0]  out;
  logic              out_strobe;
  logic              busy;

  // Operand sequencer / result collector side.
  modport master (
    output start, signed_mode, in_valid, a, b,
    input  in_ready, out, out_strobe, busy
  );

  // Engine side.
  modport slave (
    input  start, signed_mode, in_valid, a, b,
    output in_ready, out, out_strobe, busy
  );

endinterface

// File: rtl/dot_product_engine_mult_stage.sv
// rtl/dot_product_engine_mult_stage.sv - registered signed/unsigned multiplier with valid bit
module dp_mult_stage
  import dot_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int PROD_W = prod_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PROD_W-1:0] prod,
  output logic              prod_valid
);

  // One extra top bit carries the sign in signed mode and is zero otherwise,
  // so a single signed multiplier serves both modes.
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  assign a_ext = PROD_W'($signed({signed_mode & a[DATA_W-1], a}));
  assign b_ext = PROD_W'($signed({signed_mode & b[DATA_W-1], b}));

  // Capture a product for every accepted pair; clear drops stale data when no new pair arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else begin
      prod_valid <= en;
      if (en) begin
        prod <= a_ext * b_ext;
      end else if (clr) begin
        prod <= '0;
      end
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - streaming dot product of two LEN-element vectors
module dot_product_engine
  import dot_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN    = 2
) (
  input logic                 clk,
  input logic                 rst,
  dot_product_engine_if.slave bus
);

  localparam int ACC_W  = acc_width(DATA_W, LEN);
  localparam int PROD_W = prod_width(DATA_W);
  localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum;
  logic              signed_q;
  logic              mult_signed;
  logic              start_take;
  logic              accept;
  logic [PROD_W-1:0] prod;
  logic              prod_valid;

  // START is honoured in IDLE and ACC (abort); in LAST the result is allowed to finish.
  assign start_take  = bus.start && (state != ST_LAST);
  assign accept      = bus.in_valid && (start_take || (state == ST_ACC));
  // The pair arriving with START uses the new mode, later pairs the latched one.
  assign mult_signed = start_take ? bus.signed_mode : signed_q;
  assign prod_ext    = signed_q ? ACC_W'($signed(prod)) : ACC_W'(prod);
  assign sum         = acc + prod_ext;

  assign bus.in_ready = (state != ST_LAST);
  assign bus.busy     = (state != ST_IDLE);

  dp_mult_stage #(.DATA_W(DATA_W)) u_mult (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_take),
    .en          (accept),
    .signed_mode (mult_signed),
    .a           (bus.a),
    .b           (bus.b),
    .prod        (prod),
    .prod_valid  (prod_valid)
  );

  // Sequencing, element counting, accumulation and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      acc            <= '0;
      signed_q       <= 1'b0;
      bus.out        <= '0;
      bus.out_strobe <= 1'b0;
    end else begin
      bus.out_strobe <= (state == ST_LAST);
      if (state == ST_LAST) begin
        bus.out <= sum;
      end
      if (start_take) begin
        // Fresh vector or abort: any in-flight product is simply never added.
        signed_q <= bus.signed_mode;
        acc      <= '0;
        cnt      <= bus.in_valid ? CNT_W'(1) : '0;
        state    <= (bus.in_valid && (LEN == 1)) ? ST_LAST : ST_ACC;
      end else begin
        if (prod_valid) begin
          acc <= sum;
        end
        if ((state == ST_ACC) && bus.in_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= ST_LAST;
          end
        end else if (state == ST_LAST) begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb/tb_dot_product_engine.sv - self-checking bench for dot_product_engine
module tb_dot_product_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sgn = 1'b0;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  always #5 clk = ~clk;

  dot_product_engine_if #(.DATA_W(8), .LEN(2)) if2 ();
  dot_product_engine_if #(.DATA_W(8), .LEN(4)) if4 ();

  assign if2.start       = start & ~sel;
  assign if4.start       = start & sel;
  assign if2.in_valid    = in_valid & ~sel;
  assign if4.in_valid    = in_valid & sel;
  assign if2.signed_mode = sgn;
  assign if4.signed_mode = sgn;
  assign if2.a = a;
  assign if2.b = b;
  assign if4.a = a;
  assign if4.b = b;

  dot_product_engine #(.DATA_W(8), .LEN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  dot_product_engine #(.DATA_W(8), .LEN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [17:0] obs_out;
  logic        obs_strobe;
  logic        obs_busy;
  logic        obs_ready;
  assign obs_out    = sel ? if4.out : {1'b0, if2.out};
  assign obs_strobe = sel ? if4.out_strobe : if2.out_strobe;
  assign obs_busy   = sel ? if4.busy : if2.busy;
  assign obs_ready  = sel ? if4.in_ready : if2.in_ready;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     ready_bad = 0;
  int     last_set_cyc = 0;
  bit     cur_sg = 1'b0;
  longint res_q[$];
  int     rcyc_q[$];
  int     va[4];
  int     vb[4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint conv(input logic [17:0] v, input bit sg, input bit s4);
    longint x;
    int     w;
    x = longint'(v);
    w = s4 ? 18 : 17;
    if (sg && v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Reference: plain sum of products of the integer element values.
  function automatic longint model(input int len);
    longint s;
    s = 0;
    for (int i = 0; i < len; i++) s = s + longint'(va[i]) * longint'(vb[i]);
    return s;
  endfunction

  always @(negedge clk) begin
    if (obs_strobe) begin
      res_q.push_back(conv(obs_out, cur_sg, sel));
      rcyc_q.push_back(cyc);
    end
  end

  task automatic send_vec(input int len, input bit sg, input int stall);
    @(negedge clk);
    cur_sg = sg; sgn = sg; start = 1'b1; in_valid = 1'b1;
    a = 8'(va[0]); b = 8'(vb[0]); last_set_cyc = cyc;
    for (int i = 1; i < len; i++) begin
      repeat (stall) begin
        @(negedge clk);
        if (obs_ready !== 1'b1) ready_bad++;
        start = 1'b0; in_valid = 1'b0; sgn = ~sg;
        a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; sgn = ~sg;
      a = 8'(va[i]); b = 8'(vb[i]); last_set_cyc = cyc;
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int k;
    k = 0;
    while (res_q.size() < n && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (if2.out !== 17'd0) begin failures++; $display("FAIL reset_out: got %0d want 0", if2.out); end
    checks++; if (if2.out_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b want 0", if2.out_strobe); end
    checks++; if (if2.busy !== 1'b0 || if4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b%b want 00", if2.busy, if4.busy); end
    checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", if2.in_ready); end
    rst = 1'b0;
    res_q.delete();
    in_valid = 1'b1; a = 8'd9; b = 8'd9;
    repeat (3) @(negedge clk);
    checks++; if (if2.busy !== 1'b0 || res_q.size() != 0) begin failures++; $display("FAIL valid_no_start: busy %b strobes %0d want 0 0", if2.busy, res_q.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_signed_basic();
    int     tab[4][4] = '{'{5, 10, 10, 20}, '{5, -10, 10, 20}, '{5, 10, -10, 20}, '{5, -10, -10, 20}};
    longint want[4] = '{250, 150, -150, -250};
    sel = 1'b0;
    for (int t = 0; t < 4; t++) begin
      va[0] = tab[t][0]; vb[0] = tab[t][1]; va[1] = tab[t][2]; vb[1] = tab[t][3];
      res_q.delete(); rcyc_q.delete();
      send_vec(2, 1'b1, 0);
      wait_res(1);
      checks++;
      if (res_q.size() != 1) begin failures++; $display("FAIL basic%0d_count: got %0d strobes want 1", t, res_q.size()); end
      else begin
        checks++; if (res_q[0] != want[t]) begin failures++; $display("FAIL basic%0d_value: got %0d want %0d", t, res_q[0], want[t]); end
        checks++; if (rcyc_q[0] != last_set_cyc + 2) begin failures++; $display("FAIL basic%0d_latency: got %0d want %0d", t, rcyc_q[0], last_set_cyc + 2); end
      end
    end
  endtask

  task automatic test_extremes();
    sel = 1'b0;
    va = '{-128, -128, 0, 0}; vb = '{-128, -128, 0, 0};
    res_q.delete(); send_vec(2, 1'b1, 0); wait_res(1);
    checks++; if (res_q.size() != 1 || res_q[0] != 32768) begin failures++; $display("FAIL extreme_signed: got %0d results, first %0d want 32768", res_q.size(), (res_q.size() > 0) ? res_q[0] : 0); end
    va = '{255, 255, 0, 0}; vb = '{255, 255, 0, 0};
    res_q.delete(); send_vec(2, 1'b0, 0); wait_res(1);
    checks++; if (res_q.size() != 1 || res_q[0] != 130050) begin failures++; $display("FAIL extreme_unsigned: got %0d results, first %0d want 130050", res_q.size(), (res_q.size() > 0) ? res_q[0] : 0); end
  endtask

  task automatic test_stalls();
    sel = 1'b1;
    va = '{1, 2, 3, 4}; vb = '{1, 2, 3, 4};
    ready_bad = 0; res_q.delete(); rcyc_q.delete();
    send_vec(4, 1'b1, 3); wait_res(1);
    checks++; if (res_q.size() != 1 || res_q[0] != 30) begin failures++; $display("FAIL stall_value: got %0d results, first %0d want 30", res_q.size(), (res_q.size() > 0) ? res_q[0] : 0); end
    checks++; if (ready_bad != 0) begin failures++; $display("FAIL stall_ready: got %0d low cycles want 0", ready_bad); end
    checks++; if (rcyc_q.size() != 1 || rcyc_q[0] != last_set_cyc + 2) begin failures++; $display("FAIL stall_latency: got %0d want %0d", (rcyc_q.size() > 0) ? rcyc_q[0] : -1, last_set_cyc + 2); end
  endtask

  task automatic test_abort();
    sel = 1'b0; res_q.delete();
    @(negedge clk);
    cur_sg = 1'b1; sgn = 1'b1; start = 1'b1; in_valid = 1'b1; a = 8'd7; b = 8'd7;
    va = '{3, 5, 0, 0}; vb = '{4, 6, 0, 0};
    send_vec(2, 1'b1, 0); wait_res(1);
    checks++; if (res_q.size() != 1) begin failures++; $display("FAIL abort_count: got %0d strobes want 1", res_q.size()); end
    else begin
      checks++; if (res_q[0] != 42) begin failures++; $display("FAIL abort_value: got %0d want 42", res_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    longint e1, e2;
    sel = 1'b0; res_q.delete(); rcyc_q.delete();
    va = '{100, -50, 0, 0}; vb = '{3, 7, 0, 0}; e1 = model(2);
    send_vec(2, 1'b1, 0);
    va = '{-20, 11, 0, 0}; vb = '{9, -4, 0, 0}; e2 = model(2);
    send_vec(2, 1'b1, 0);
    wait_res(2);
    checks++;
    if (res_q.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d strobes want 2", res_q.size()); end
    else begin
      checks++; if (res_q[0] != e1 || res_q[1] != e2) begin failures++; $display("FAIL b2b_values: got %0d %0d want %0d %0d", res_q[0], res_q[1], e1, e2); end
      checks++; if (rcyc_q[1] - rcyc_q[0] != 3) begin failures++; $display("FAIL b2b_spacing: got %0d want 3", rcyc_q[1] - rcyc_q[0]); end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; res_q.delete();
    @(negedge clk);
    cur_sg = 1'b1; sgn = 1'b1; start = 1'b1; in_valid = 1'b1; a = 8'd9; b = 8'd9;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (obs_out !== 18'd0 || obs_busy !== 1'b0) begin failures++; $display("FAIL rst_mid: out %0d busy %b want 0 0", obs_out, obs_busy); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (res_q.size() != 0) begin failures++; $display("FAIL rst_mid_strobe: got %0d strobes want 0", res_q.size()); end
    va = '{-3, 7, 0, 0}; vb = '{4, -2, 0, 0};
    send_vec(2, 1'b1, 0); wait_res(1);
    checks++; if (res_q.size() != 1 || res_q[0] != -26) begin failures++; $display("FAIL rst_mid_after: got %0d results, first %0d want -26", res_q.size(), (res_q.size() > 0) ? res_q[0] : 0); end
  endtask

  task automatic test_random();
    int     len;
    bit     sg;
    longint exp_v;
    for (int n = 0; n < 100; n++) begin
      sel = 1'($urandom_range(0, 1));
      len = sel ? 4 : 2;
      sg  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        va[i] = sg ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 255));
        vb[i] = sg ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 255));
      end
      exp_v = model(len);
      res_q.delete();
      send_vec(len, sg, int'($urandom_range(0, 2)));
      wait_res(1);
      checks++;
      if (res_q.size() != 1 || res_q[0] != exp_v) begin
        failures++;
        $display("FAIL random%0d: len %0d signed %0d got %0d results, first %0d want %0d", n, len, sg, res_q.size(), (res_q.size() > 0) ? res_q[0] : 0, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_extremes();
    test_stalls();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
